cond_jump_pc_unit: RTL and testbench

- Minimal program-counter and conditional-jump sequencer for a tiny teaching CPU datapath.
- Decodes a 2-bit opcode (b0,a0) and a status flag into a registered jump request.
- Advances a PC_W-bit program counter each enabled cycle.
- When the jump request is pending, loads the PC with a target formed from the opcode bits instead of incrementing.

---
 rtl/cond_jump_pc_unit.sv | 64 ++++++
 tb/tb_cond_jump_pc_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_jump_pc_unit.sv
// Program counter with a registered conditional-jump request for a teaching CPU.
// Optional saturating jump counter is enabled by defining JUMP_COUNT_EN.
module cond_jump_pc_unit #(
  parameter int PC_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a0,
  input  logic            b0,
  input  logic            status,
  input  logic            enable,
  output logic [PC_W-1:0] pc,
  output logic            jump_taken
`ifdef JUMP_COUNT_EN
  ,
  output logic [CNT_W-1:0] jump_count
`endif
);

  logic            cond;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_next;
  logic            jump_next;

  // Jump is requested for opcode 2'b10 when the ALU flag is clear.
  assign cond = b0 & ~a0 & ~status;

  always_comb begin
    tgt    = '0;
    tgt[1] = b0 & enable;
    tgt[0] = a0 & enable;
  end

  always_comb begin
    pc_next   = pc;
    jump_next = jump_taken;
    if (enable) begin
      jump_next = cond;
      if (jump_taken) pc_next = tgt;
      else            pc_next = pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      jump_taken <= 1'b0;
    end else begin
      pc         <= pc_next;
      jump_taken <= jump_next;
    end
  end

`ifdef JUMP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      jump_count <= '0;
    else if (enable && jump_taken && (jump_count != '1))
      jump_count <= jump_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_cond_jump_pc_unit.sv
// Scoreboard bench for cond_jump_pc_unit; expectations come from a behavioural
// model pushed at stimulus time plus fixed values for the directed scenarios.
module tb_cond_jump_pc_unit;
  localparam int PC_W  = 2;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             jt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk, rst, a0, b0, status, enable;
  logic [PC_W-1:0]  pc;
  logic             jump_taken;
  logic [CNT_W-1:0] cnt_obs;
  exp_t obs, exp_v;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [PC_W-1:0]  m_pc;
  logic             m_jt;
  logic [CNT_W-1:0] m_cnt;

  cond_jump_pc_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a0        (a0),
    .b0        (b0),
    .status    (status),
    .enable    (enable),
    .pc        (pc),
    .jump_taken(jump_taken)
`ifdef JUMP_COUNT_EN
    ,
    .jump_count(cnt_obs)
`endif
  );

`ifndef JUMP_COUNT_EN
  assign cnt_obs = '0;
`endif

  assign obs = '{pc: pc, jt: jump_taken, cnt: cnt_obs};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, push its expectation.
  task automatic drive(input logic r, input logic e, input logic b, input logic a, input logic s);
    logic [PC_W-1:0] tgt;
    exp_t x;
    @(negedge clk);
    rst = r; enable = e; b0 = b; a0 = a; status = s;
    tgt    = '0;
    tgt[1] = b & e;
    tgt[0] = a & e;
    if (r) begin
      m_pc = '0; m_jt = 1'b0; m_cnt = '0;
    end else if (e) begin
      if (m_jt) begin
        m_pc = tgt;
`ifdef JUMP_COUNT_EN
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
`endif
      end else begin
        m_pc = m_pc + 1'b1;
      end
      m_jt = b & ~a & ~s;
    end
    x = '{pc: m_pc, jt: m_jt, cnt: m_cnt};
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || pc !== 2'd0 || jump_taken !== 1'b0 || cnt_obs !== '0) begin
        failures++;
        $display("FAIL reset[%0d] got pc=%0d jt=%b cnt=%0d want pc=0 jt=0 cnt=0", i, pc, jump_taken, cnt_obs);
      end
    end
  endtask

  task automatic test_increment();
    logic [PC_W-1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || pc !== seq[i] || jump_taken !== 1'b0) begin
        failures++;
        $display("FAIL increment[%0d] got pc=%0d jt=%b want pc=%0d jt=0 (model %0d/%b)", i, pc, jump_taken, seq[i], exp_v.pc, exp_v.jt);
      end
    end
  endtask

  task automatic test_jump();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd1 || jump_taken !== 1'b1) begin
      failures++;
      $display("FAIL jump_request got pc=%0d jt=%b want pc=1 jt=1", pc, jump_taken);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd3 || jump_taken !== 1'b0) begin
      failures++;
      $display("FAIL jump_redirect got pc=%0d jt=%b cnt=%0d want pc=3 jt=0 cnt=%0d", pc, jump_taken, cnt_obs, exp_v.cnt);
    end
`ifdef JUMP_COUNT_EN
    checks++;
    if (cnt_obs !== 3'd1) begin
      failures++;
      $display("FAIL jump_count got %0d want 1", cnt_obs);
    end
`endif
  endtask

  task automatic test_status_blocks();
    logic [PC_W-1:0] want [2];
    want = '{2'd1, 2'd2};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== want[0] || jump_taken !== 1'b0) begin
      failures++;
      $display("FAIL status_block0 got pc=%0d jt=%b want pc=1 jt=0", pc, jump_taken);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== want[1] || jump_taken !== 1'b0) begin
      failures++;
      $display("FAIL status_block1 got pc=%0d jt=%b want pc=2 jt=0", pc, jump_taken);
    end
  endtask

  task automatic test_enable_hold();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd3 || jump_taken !== 1'b1) begin
      failures++;
      $display("FAIL hold_setup got pc=%0d jt=%b want pc=3 jt=1", pc, jump_taken);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || pc !== 2'd3 || jump_taken !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d] got pc=%0d jt=%b want pc=3 jt=1", i, pc, jump_taken);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd2 || jump_taken !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got pc=%0d jt=%b want pc=2 jt=1", pc, jump_taken);
    end
  endtask

  task automatic test_back_to_back();
    // Repeated opcode 2'b10 keeps redirecting to 2 and drives the counter to saturation.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || pc !== 2'd2 || jump_taken !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d] got pc=%0d jt=%b cnt=%0d want pc=2 jt=1 cnt=%0d", i, pc, jump_taken, cnt_obs, exp_v.cnt);
      end
    end
`ifdef JUMP_COUNT_EN
    checks++;
    if (cnt_obs !== 3'd7) begin
      failures++;
      $display("FAIL count_saturate got %0d want 7", cnt_obs);
    end
`endif
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd0 || jump_taken !== 1'b0 || cnt_obs !== '0) begin
      failures++;
      $display("FAIL reset_pending got pc=%0d jt=%b cnt=%0d want pc=0 jt=0 cnt=0", pc, jump_taken, cnt_obs);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    checks++;
    if (obs !== exp_v || pc !== 2'd1 || jump_taken !== 1'b0) begin
      failures++;
      $display("FAIL no_redirect_after_reset got pc=%0d jt=%b want pc=1 jt=0", pc, jump_taken);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random[%0d] got pc=%0d jt=%b cnt=%0d want pc=%0d jt=%b cnt=%0d",
                 i, pc, jump_taken, cnt_obs, exp_v.pc, exp_v.jt, exp_v.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; a0 = 1'b0; b0 = 1'b0; status = 1'b0;
    test_reset();
    test_increment();
    test_jump();
    test_status_blocks();
    test_enable_hold();
    test_back_to_back();
    test_reset_pending();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
